seg7_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Drives all digits through one shared instance of the team's BCD-to-segment decoder (segLED). It cycles the digit enables and inserts a blanking gap between digits to stop ghosting.
- Host writes a new BCD word with a single-cycle load. The word is applied only at a frame boundary, so the display never tears.

---
 rtl/seg7_scan_ctrl_pkg.sv | 20 ++
 rtl/seg7_scan_ctrl_segled.sv | 27 ++
 rtl/seg7_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan controller.
//   scan_state_t : slot phase (BLANK = all digits off, SHOW = one digit lit)
//   SEG_OFF      : full 8-bit segment word with everything dark (active-low)
//   SEG_BLANK7   : 7-bit glyph field with every segment dark
//   cnt_width()  : bit width needed for a slot counter running 0..div-1
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [6:0] SEG_BLANK7 = 7'h7F;

  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_segled.sv
// segLED: combinational BCD-to-segment decoder of the display board.
//   bcd_i [3:0] : BCD digit; codes above 9 decode to all segments dark
//   seg_o [6:0] : glyph, active-low, in the board wiring order
//                 [6]=b [5]=c [4]=a [3]=e [2]=f [1]=d [0]=g
module segLED (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (bcd_i)
      4'd0: seg_o = 7'h01;  // a b c d e f
      4'd1: seg_o = 7'h1F;  // b c
      4'd2: seg_o = 7'h24;  // a b d e g
      4'd3: seg_o = 7'h0C;  // a b c d g
      4'd4: seg_o = 7'h1A;  // b c f g
      4'd5: seg_o = 7'h48;  // a c d f g
      4'd6: seg_o = 7'h40;  // a c d e f g
      4'd7: seg_o = 7'h0F;  // a b c
      4'd8: seg_o = 7'h00;  // all
      4'd9: seg_o = 7'h08;  // a b c d f g
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display, sharing one segLED decoder across digits.
// Each digit slot is SCAN_DIV cycles: BLANK_CYC dark cycles, then the digit.
// A loaded word is staged and only applied at the frame boundary.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   load       : single-cycle strobe capturing value / dp_mask
//   value      : BCD digits, digit i = value[4i+3:4i], digit 0 rightmost
//   dp_mask    : per-digit decimal point enable (1 = lit)
//   seg        : {a..g glyph, dp}, active-low, registered
//   an         : digit enables, active-low, registered
//   frame_done : one-cycle pulse after the last slot of each frame
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_W = cnt_width(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  scan_state_t             state_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, pend_q;
  logic [NUM_DIGITS-1:0]   dpd_q, pdp_q;
  logic                    pflag_q;
  logic [7:0]              seg_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    fd_q;

  logic                    wrap, boundary;
  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic [NUM_DIGITS-1:0]   an_show;
  logic                    lz_blank;
  logic [6:0]              dec_seg;

  assign wrap     = (cnt_q == CNT_LAST);
  assign boundary = wrap && (idx_q == IDX_LAST);
  assign cnt_d    = wrap ? '0 : cnt_q + 1'b1;
  assign idx_d    = !wrap ? idx_q : ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1);

  // Digit mux and one-hot-low enable for the current slot.
  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    an_show   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit  = disp_q[4*i +: 4];
        cur_dp     = dpd_q[i];
        an_show[i] = 1'b0;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more significant digit are 0.
  always_comb begin
    lz_blank = (idx_q != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx_q) && (disp_q[4*i +: 4] != 4'd0)) lz_blank = 1'b0;
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  segLED u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      dpd_q   <= '0;
      pend_q  <= '0;
      pdp_q   <= '0;
      pflag_q <= 1'b0;
      seg_q   <= SEG_OFF;
      an_q    <= '1;
      fd_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;

      case (state_q)
        BLANK:   if (cnt_d == CNT_SHOW) state_q <= SHOW;
        SHOW:    if (wrap) state_q <= BLANK;
        default: state_q <= BLANK;
      endcase

      // Outputs reflect the state/counter/index of this cycle, one cycle late.
      if (state_q == SHOW) begin
        an_q  <= an_show;
        seg_q <= {(lz_blank ? SEG_BLANK7 : dec_seg), ~cur_dp};
      end else begin
        an_q  <= '1;
        seg_q <= SEG_OFF;
      end
      fd_q <= boundary;

      // A load on the boundary bypasses staging so no stale frame is shown.
      if (boundary) begin
        if (load) begin
          disp_q <= value;
          dpd_q  <= dp_mask;
        end else if (pflag_q) begin
          disp_q <= pend_q;
          dpd_q  <= pdp_q;
        end
        pflag_q <= 1'b0;
      end else if (load) begin
        pend_q  <= value;
        pdp_q   <= dp_mask;
        pflag_q <= 1'b1;
      end
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2).
// The reference model derives slot/digit position from the time elapsed
// since reset and glyphs from lit-segment sets; it honours the
// SEG7_LEADING_ZERO_BLANK_EN macro the same way the design build does.
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int SD = 8;
  localparam int BL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  typedef struct {
    int         stamp;
    logic [7:0] seg;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   pcount = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) pcount++;

  // Reference model state
  int         t = 0;
  logic [3:0] m_dig [N];
  logic [3:0] m_dp = '0;
  logic [15:0] p_val = '0;
  logic [3:0] p_dp = '0;
  bit         p_flag = 1'b0;

  // Lit segments of each decimal digit, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] lit_set(input int d);
    case (d)
      0: return 7'h7E; 1: return 7'h30; 2: return 7'h6D; 3: return 7'h79;
      4: return 7'h33; 5: return 7'h5B; 6: return 7'h5F; 7: return 7'h70;
      8: return 7'h7F; 9: return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  // Board wiring of the glyph field: b c a e f d g, active-low.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] l;
    l = lit_set(int'(d));
    return ~{l[5], l[4], l[6], l[2], l[1], l[3], l[0]};
  endfunction

  task automatic set_disp(input logic [15:0] v, input logic [3:0] dp);
    for (int j = 0; j < N; j++) m_dig[j] = v[4*j +: 4];
    m_dp = dp;
  endtask

  task automatic step(input bit r, input bit ld, input logic [15:0] v, input logic [3:0] dp);
    exp_t e;
    int   cnt, idx;
    bit   bnd, blank;
    @(posedge clk);
    #3;
    rst_n   = ~r;
    load    = ld;
    value   = v;
    dp_mask = dp;
    e.stamp = pcount + 1;
    if (r) begin
      e.seg = 8'hFF; e.an = 4'hF; e.fd = 1'b0;
      t = 0; set_disp(16'h0, 4'h0); p_flag = 1'b0;
    end else begin
      cnt = t % SD;
      idx = (t / SD) % N;
      bnd = (idx == N - 1) && (cnt == SD - 1);
      e.fd = bnd;
      if (cnt < BL) begin
        e.seg = 8'hFF; e.an = 4'hF;
      end else begin
        blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (idx > 0) begin
          blank = 1'b1;
          for (int j = idx; j < N; j++) if (m_dig[j] != 0) blank = 1'b0;
        end
`endif
        e.seg = {(blank ? 7'h7F : glyph(m_dig[idx])), ~m_dp[idx]};
        e.an = 4'hF;
        e.an[idx] = 1'b0;
      end
      if (bnd) begin
        if (ld) set_disp(v, dp);
        else if (p_flag) set_disp(p_val, p_dp);
        p_flag = 1'b0;
      end else if (ld) begin
        p_val = v; p_dp = dp; p_flag = 1'b1;
      end
      t++;
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic to_slot_end;
    // Advance until the next cycle to be issued is the frame boundary.
    while ((t % (SD * N)) != (SD * N - 1)) step(1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  // Monitor: compare every output cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].stamp <= pcount) begin
        e = sb.pop_front();
        checks++;
        if (e.stamp != pcount) begin
          errors++;
          $display("FAIL cycle_align: entry for cycle %0d seen at cycle %0d", e.stamp, pcount);
        end else if (seg !== e.seg || an !== e.an || frame_done !== e.fd) begin
          errors++;
          $display("FAIL outputs@%0d: got seg=%h an=%h fd=%b, want seg=%h an=%h fd=%b",
                   pcount, seg, an, frame_done, e.seg, e.an, e.fd);
        end
      end
    end
  end

  initial begin
    logic [31:0] rv, rd;
    set_disp(16'h0, 4'h0);
    // Reset held, then free-run with no load for two frames.
    repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0);
    idle(70);
    // Mid-frame load of 1234 with dp on digit 1.
    step(1'b0, 1'b1, 16'h1234, 4'b0010);
    idle(70);
    // Two loads in one frame: last one wins.
    idle(5);
    step(1'b0, 1'b1, 16'h0001, 4'h0);
    idle(3);
    step(1'b0, 1'b1, 16'h0009, 4'h0);
    idle(60);
    // Load exactly on the boundary cycle.
    to_slot_end();
    step(1'b0, 1'b1, 16'h5555, 4'h0);
    idle(40);
    // Codes above 9.
    step(1'b0, 1'b1, 16'hA0F9, 4'b0101);
    idle(70);
    // Leading zeros.
    step(1'b0, 1'b1, 16'h0040, 4'h0);
    idle(70);
    // Reset mid-frame discards a pending word.
    idle(3);
    step(1'b0, 1'b1, 16'h8888, 4'hF);
    idle(4);
    repeat (2) step(1'b1, 1'b0, 16'h0, 4'h0);
    idle(70);
    // Randomized traffic with occasional resets.
    repeat (800) begin
      rv = $urandom;
      rd = $urandom;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0), rv[15:0], rd[3:0]);
    end
    idle(2);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
